// File: rtl/game_pkg.sv
// Shared definitions for the gamepad input stage: button indices, SNES
// serial frame layout, FSM state encoding and frame decode helpers.
package game_pkg;

  // Debounced button bit positions (same order in both halves of input_data).
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_W      = 5;

  // Bit positions within the 16-bit SNES serial frame, in shift order.
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;
  localparam int SNES_SIG_LO = 12;
  localparam int SNES_SIG_HI = 15;
  localparam int SNES_BITS   = 16;

  // Poll sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_CLK_HIGH = 3'd2,
    ST_CLK_LOW  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // A real pad leaves its signature lines high, which reads back as zeros
  // once the active-low data has been inverted into the raw frame.
  function automatic logic sig_present(input logic [SNES_BITS-1:0] raw);
    return (raw[SNES_SIG_HI:SNES_SIG_LO] == 4'b0000);
  endfunction

  // Map the raw frame onto the five game buttons; A and B both mean attack.
  function automatic logic [BTN_W-1:0] frame_to_sample(input logic [SNES_BITS-1:0] raw);
    logic [BTN_W-1:0] s;
    s             = '0;
    s[BTN_UP]     = raw[SNES_UP];
    s[BTN_DOWN]   = raw[SNES_DOWN];
    s[BTN_LEFT]   = raw[SNES_LEFT];
    s[BTN_RIGHT]  = raw[SNES_RIGHT];
    s[BTN_ATTACK] = raw[SNES_A] | raw[SNES_B];
    return s;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-poll debounce of the decoded button sample plus pressed/released edge
// pulse generation. Everything is evaluated once per poll on the done strobe.
module button_debounce
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 done,
  input  logic [BTN_W-1:0]     sample,
  output logic [2*BTN_W-1:0]   input_data,
  output logic [BTN_W-1:0]     buttons
);

  logic [BTN_W-1:0]   prev_r;
  logic [BTN_W-1:0]   buttons_r;
  logic [2*BTN_W-1:0] input_data_r;

  logic [BTN_W-1:0]   new_s;
  logic [BTN_W-1:0]   pressed_s;
  logic [BTN_W-1:0]   released_s;

  // Accept a new level only when two consecutive polls agree, then derive edges.
  always_comb begin
    new_s      = buttons_r;
    pressed_s  = '0;
    released_s = '0;
    if (sample == prev_r) begin
      new_s = sample;
    end else begin
      new_s = buttons_r;
    end
    pressed_s  = new_s & ~buttons_r;
    released_s = ~new_s & buttons_r;
  end

  // Debounce state and the one-cycle edge pulse register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_r       <= '0;
      buttons_r    <= '0;
      input_data_r <= '0;
    end else if (done) begin
      prev_r       <= sample;
      buttons_r    <= new_s;
      input_data_r <= {pressed_s, released_s};
    end else begin
      input_data_r <= '0;
    end
  end

  assign input_data = input_data_r;
  assign buttons    = buttons_r;

endmodule

// File: rtl/gamepad_input.sv
// SNES-style gamepad poller: on each poll request it latches the pad, clocks
// out 16 serial bits, decodes the five game buttons and hands them to the
// debounce stage, which emits pressed/released pulses during the DONE cycle.
module gamepad_input
  import game_pkg::*;
#(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll,
  input  logic        gamepad_data,
  output logic        gamepad_latch,
  output logic        gamepad_clk,
  output logic [9:0]  input_data,
  output logic [4:0]  buttons,
  output logic        pad_present,
  output logic        busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX   = 4'd15;

  state_t                 state_r;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next;
  logic [3:0]             idx_r;
  logic [3:0]             idx_next;
  logic [SNES_BITS-1:0]   raw_r;
  logic [SNES_BITS-1:0]   raw_next;
  logic [1:0]             sync_r;

  logic                   latch_r;
  logic                   pclk_r;
  logic                   busy_r;
  logic                   pad_present_r;

  logic                   data_bit_s;
  logic                   finish_s;
  logic                   present_s;
  logic [BTN_W-1:0]       sample_s;

  // Pad data is asynchronous; bring it into the clk domain through two flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], gamepad_data};
    end
  end

  // Pad data is active-low, so a pressed button shows up as a 1 in raw.
  assign data_bit_s = ~sync_r[1];

  // Next-state, phase counter, bit index and shift register update.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    idx_next   = idx_r;
    raw_next   = raw_r;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (poll) begin
          state_next = ST_LATCH;
          cnt_next   = LATCH_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (cnt_r == '0) begin
          state_next = ST_CLK_HIGH;
          cnt_next   = HALF_LOAD;
          idx_next   = 4'd0;
        end else begin
          cnt_next = cnt_r - CNT_W'(1);
        end
      end
      ST_CLK_HIGH: begin
        if (cnt_r == '0) begin
          // Sample on the last cycle of the high phase, when data is settled.
          raw_next[idx_r] = data_bit_s;
          if (idx_r == LAST_IDX) begin
            state_next = ST_DONE;
            finish_s   = 1'b1;
          end else begin
            state_next = ST_CLK_LOW;
            cnt_next   = HALF_LOAD;
          end
        end else begin
          cnt_next = cnt_r - CNT_W'(1);
        end
      end
      ST_CLK_LOW: begin
        if (cnt_r == '0) begin
          state_next = ST_CLK_HIGH;
          cnt_next   = HALF_LOAD;
          idx_next   = idx_r + 4'd1;
        end else begin
          cnt_next = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Sequencer state register with counters and the received frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 4'd0;
      raw_r   <= '0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      idx_r   <= idx_next;
      raw_r   <= raw_next;
    end
  end

  // Decode from the frame including the bit captured this cycle, so the
  // debounce result is registered and visible throughout the DONE cycle.
  assign present_s = sig_present(raw_next);

  // A missing pad reads as all-pressed; suppress it so nothing is reported.
  always_comb begin
    sample_s = '0;
    if (present_s) begin
      sample_s = frame_to_sample(raw_next);
    end else begin
      sample_s = '0;
    end
  end

  // Pad pins and status flags are registered from the next state to stay glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_r       <= 1'b0;
      pclk_r        <= 1'b1;
      busy_r        <= 1'b0;
      pad_present_r <= 1'b0;
    end else begin
      latch_r <= (state_next == ST_LATCH);
      pclk_r  <= (state_next != ST_CLK_LOW);
      busy_r  <= (state_next != ST_IDLE);
      if (finish_s) begin
        pad_present_r <= present_s;
      end else begin
        pad_present_r <= pad_present_r;
      end
    end
  end

  button_debounce u_debounce (
    .clk        (clk),
    .reset      (reset),
    .done       (finish_s),
    .sample     (sample_s),
    .input_data (input_data),
    .buttons    (buttons)
  );

  assign gamepad_latch = latch_r;
  assign gamepad_clk   = pclk_r;
  assign busy          = busy_r;
  assign pad_present   = pad_present_r;

endmodule

// File: doc/gamepad_input.md
# gamepad_input

Upstream input stage for the player FSM: polls an SNES-style serial gamepad once per `poll` request, synchronises and debounces the button states, and emits one-cycle pressed/released edge pulses. The pulses are packed as `input_data` and feed the player logic's 10-bit input bus directly. Latch and clock pins go to the gamepad; the data pin comes back through a 2-FF synchroniser.

## Interface
- `LATCH_CYCLES`, 300: gamepad latch high time in `clk` cycles (12 µs at 25 MHz).
- `HALF_CYCLES`, 150: half-period of the gamepad clock in `clk` cycles; must be ≥ 4.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low; `reset == 0` resets the block on the next `clk` edge.
- `poll`  in  1  one-cycle request to start a read; typically frame start.
- `gamepad_data`  in  1  serial data from the pad, asynchronous, active-low (0 = button pressed).
- `gamepad_latch`  out  1  latch strobe to the pad.
- `gamepad_clk`  out  1  shift clock to the pad; idles high.
- `input_data`  out  10  `{pressed[4:0], released[4:0]}`; bit order in each half is `[0]` up, `[1]` down, `[2]` left, `[3]` right, `[4]` attack.
- `buttons`  out  5  debounced level state, same bit order.
- `pad_present`  out  1  1 when the last completed poll saw a valid pad signature.
- `busy`  out  1  high from poll acceptance until the end of DONE.

## Operation
- FSM states are IDLE, LATCH, CLK_HIGH, CLK_LOW and DONE. A down-counter (`cnt`) sets phase lengths, and a 4-bit bit index (`idx`) counts received bits.
- IDLE: `latch=0`, `clk=1`. If `poll=1`, go to LATCH and load `cnt=LATCH_CYCLES-1`. `poll` is ignored in every other state.
- LATCH: `latch=1` until `cnt==0`, then go to CLK_HIGH with `idx=0` and `cnt=HALF_CYCLES-1`.
- CLK_HIGH: `clk=1`. When `cnt==0`, store the synchronised data bit, inverted, in `raw[idx]`.
  - If `idx==15`, go to DONE.
  - Otherwise go to CLK_LOW.
- CLK_LOW: `clk=0` for HALF_CYCLES, then go to CLK_HIGH with `idx+1`.
- Raw frame bit mapping: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12–15 signature.
  - `sample = {raw[0]|raw[8], raw[7], raw[6], raw[5], raw[4]}`, giving attack, right, left, down, up.
- Presence check: `present = (raw[15:12]==4'b0000)`, meaning all signature lines read electrically high. If not present, force `sample=0`.
- DONE (one cycle):
  - Debounce: if `sample == prev_sample`, then `new = sample`; otherwise `new = buttons`.
  - `pressed = new & ~buttons`; `released = ~new & buttons`; `input_data = {pressed, released}`.
  - Update `buttons <= new`, `prev_sample <= sample`, `pad_present <= present`.
  - Return to IDLE.
- `input_data` is zero in every cycle except DONE. `pressed` and `released` are never both set for the same bit.
- Reset, including mid-poll:
  - State returns to IDLE.
  - Outputs: `gamepad_latch=0`, `gamepad_clk=1`, `input_data=0`, `buttons=0`, `pad_present=0`, `busy=0`.
  - Clear `prev_sample`, `raw`, `cnt`, `idx` and the synchroniser.
  - No edge pulse is generated by reset.

## Timing
- `poll` registered in IDLE: `gamepad_latch` rises on the next cycle.
- Latch width is exactly LATCH_CYCLES. Each clock phase is exactly HALF_CYCLES.
- The pad clock has 15 low pulses. Bit 0 (B) is sampled before the first falling edge.
- Poll duration, from the first LATCH cycle to DONE inclusive: `LATCH_CYCLES + 31*HALF_CYCLES + 1` cycles. Defaults give 4951.
- Each bit is sampled on the last cycle of its high phase. The data has settled for ≥ HALF_CYCLES−2 cycles after the synchroniser.
- A debounced change needs two consecutive agreeing polls. Its edge pulse appears in the DONE cycle of the second poll.

## Structure
- Shared package (`game_pkg`):
  - button index localparams (`BTN_UP=0` … `BTN_ATTACK=4`)
  - SNES frame bit indices
  - the 3-bit state encoding
- One sub-module, `button_debounce`: holds `prev_sample`/`buttons` and performs the edge computation, enabled by a `done` strobe. The parent module contains the FSM, counters, synchroniser and shift register.

## Test plan
- Reset then one poll with the pad model idle (all data 1, signature high): `buttons=0`, `input_data=0`, `pad_present=1`. Count latch width = 300 and clk low pulses = 15.
- Up held for polls 1–2: poll 1 DONE gives `input_data=0`; poll 2 DONE gives `input_data=10'b00001_00000` for exactly one cycle and `buttons=5'b00001`.
- A+B held for two polls, then released for two polls: attack pressed `10'b10000_00000`, later released `10'b00000_10000`.
- Right glitches for a single poll only: no pulse and `buttons` unchanged.
- Pad disconnected (data stuck 0) after Left has been stable: `pad_present=0`. After two such polls, Left is released (`10'b00000_00100`). No spurious presses.
- `reset` asserted during CLK_LOW of bit 7: next cycle `gamepad_clk=1` and `latch=0`, with FSM in IDLE. A `poll` pulse during `busy` is ignored, and exactly one DONE occurs per accepted poll.
